// File: rtl/inpack.sv
// Pixel packer: collects RGB pixels into 64-bit words with frame-buffer addresses and queues them for a memory writer.
// Define INPACK_RGB565_EN to pack four RGB565 pixels per word instead of two 32-bit {00,R,G,B} pixels.
module inpack #(
  parameter int WIDTH  = 720,
  parameter int HEIGHT = 576,
  parameter int DEPTH  = 16
) (
  input  logic        adclk,
  input  logic        adrst_n,
  input  logic        inde,
  input  logic [25:0] indat,
  input  logic [31:0] fbbase,
  output logic        wrvalid,
  input  logic        wrready,
  output logic [31:0] wraddr,
  output logic [63:0] wrdata,
  output logic        overflow,
  output logic        fdone
);

`ifdef INPACK_RGB565_EN
  localparam int LANES  = 4;
  localparam int LANE_W = 16;
  localparam int BPP    = 2;
`else
  localparam int LANES  = 2;
  localparam int LANE_W = 32;
  localparam int BPP    = 4;
`endif
  localparam int LB = $clog2(LANES);
  localparam int XW = $clog2(WIDTH + 1);
  localparam int YW = $clog2(HEIGHT + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {WAITSOF, ACTIVE, DONE} state_t;

  state_t            state, state_next;
  logic [XW-1:0]     x, x_cur, x_next, x_first;
  logic [YW-1:0]     line, line_cur;
  logic [31:0]       base, base_next, push_addr;
  logic [63:0]       part, part_cur, part_next, word;
  logic [LB-1:0]     lane;
  logic [LANE_W-1:0] lane_val;
  logic              sof, sol, take, push, clr_ovf, done_next;
  logic              pop, full, push_ok;
  logic [95:0]       mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;

  assign sof = indat[25];
  assign sol = indat[24];

`ifdef INPACK_RGB565_EN
  logic unused_rgb;
  assign lane_val   = {indat[23:19], indat[15:10], indat[7:3]};
  assign unused_rgb = ^{indat[18:16], indat[9:8], indat[2:0]};
`else
  assign lane_val = {8'h00, indat[23:0]};
`endif

  // Resolve the pixel position for this cycle, then drop it into its lane of the word being built.
  always_comb begin
    state_next = state;
    x_cur      = x;
    line_cur   = line;
    base_next  = base;
    part_cur   = part;
    take       = 1'b0;
    clr_ovf    = 1'b0;
    done_next  = 1'b0;
    if (inde) begin
      if (sof) begin
        state_next = ACTIVE;
        x_cur      = '0;
        line_cur   = '0;
        base_next  = fbbase;
        part_cur   = '0;
        clr_ovf    = 1'b1;
        take       = 1'b1;
      end else if (state == ACTIVE) begin
        if (sol) begin
          part_cur = '0;
          if (line == YW'(HEIGHT - 1)) begin
            state_next = DONE;
          end else begin
            line_cur = line + YW'(1);
            x_cur    = '0;
            take     = 1'b1;
          end
        end else begin
          take = 1'b1;
        end
      end
    end
    take = take && (x_cur < XW'(WIDTH));
    lane = x_cur[LB-1:0];
    word = part_cur;
    for (int i = 0; i < LANES; i++) begin
      if (take && lane == LB'(i)) word[i*LANE_W +: LANE_W] = lane_val;
    end
    push      = take && (lane == LB'(LANES - 1));
    x_first   = x_cur & ~XW'(LANES - 1);
    push_addr = base_next + 32'(BPP) * (32'(line_cur) * 32'(WIDTH) + 32'(x_first));
    x_next    = take ? x_cur + XW'(1) : x_cur;
    part_next = push ? '0 : word;
    if (take && x_cur == XW'(WIDTH - 1) && line_cur == YW'(HEIGHT - 1)) begin
      state_next = DONE;
      done_next  = 1'b1;
    end
  end

  assign pop     = wrvalid && wrready;
  assign full    = (count == CW'(DEPTH));
  assign push_ok = push && (!full || pop);
  assign wrvalid = (count != '0);
  assign {wraddr, wrdata} = wrvalid ? mem[rd_ptr] : '0;

  always_ff @(posedge adclk or negedge adrst_n) begin
    if (!adrst_n) begin
      state    <= WAITSOF;
      x        <= '0;
      line     <= '0;
      base     <= '0;
      part     <= '0;
      overflow <= 1'b0;
      fdone    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_next;
      x     <= x_next;
      line  <= line_cur;
      base  <= base_next;
      part  <= part_next;
      fdone <= done_next;
      if (clr_ovf) overflow <= 1'b0;
      else if (push && full && !pop) overflow <= 1'b1;
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push_ok && !pop) count <= count + CW'(1);
      else if (pop && !push_ok) count <= count - CW'(1);
    end
  end

  // Storage needs no reset: the read side is gated by the reset-cleared count.
  always_ff @(posedge adclk) begin
    if (push_ok) mem[wr_ptr] <= {push_addr, word};
  end

endmodule

// File: tb/tb_inpack.sv
// Self-checking bench for inpack: directed vector table, hand-written corner sequences and randomized traffic
// checked cycle by cycle against a queue-based reference model.
module tb_inpack;
  localparam int W = 8;
  localparam int H = 12;
  localparam int D = 16;
`ifdef INPACK_RGB565_EN
  localparam int LANES  = 4;
  localparam int LANE_W = 16;
  localparam int BPP    = 2;
`else
  localparam int LANES  = 2;
  localparam int LANE_W = 32;
  localparam int BPP    = 4;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        inde = 1'b0;
  logic [25:0] indat = '0;
  logic [31:0] fbbase = '0;
  logic        wrready = 1'b0;
  logic        wrvalid;
  logic [31:0] wraddr;
  logic [63:0] wrdata;
  logic        overflow;
  logic        fdone;

  inpack #(.WIDTH(W), .HEIGHT(H), .DEPTH(D)) dut (
    .adclk(clk), .adrst_n(rst_n), .inde(inde), .indat(indat), .fbbase(fbbase),
    .wrvalid(wrvalid), .wrready(wrready), .wraddr(wraddr), .wrdata(wrdata),
    .overflow(overflow), .fdone(fdone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
  } word_t;

  typedef struct {
    logic        inde;
    logic [25:0] dat;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_addr;
    logic [63:0] exp_data;
  } vec_t;

  // Reference model: pending pixels of the current word and the queue of words the writer should see.
  word_t       q[$];
  logic [63:0] pix[$];
  int          m_mode;
  int          m_x, m_line;
  logic [31:0] m_base;
  logic        m_ovf, m_fdone;

  int errors = 0;
  int checks = 0;
  int dut_fdones = 0;
  int dut_pops = 0;

  function automatic logic [63:0] lane_of(logic [23:0] rgb);
`ifdef INPACK_RGB565_EN
    return {48'h0, rgb[23:19], rgb[15:10], rgb[7:3]};
`else
    return {40'h0, rgb};
`endif
  endfunction

  task automatic check_output(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    pix.delete();
    m_mode = 0; m_x = 0; m_line = 0; m_base = '0; m_ovf = 1'b0; m_fdone = 1'b0;
  endtask

  task automatic model_pixel(bit full_pre, bit popped);
    word_t w;
    if (m_x >= W) return;
    pix.push_back(lane_of(indat[23:0]));
    if (pix.size() == LANES) begin
      w.data = '0;
      for (int i = 0; i < LANES; i++) w.data = w.data | (pix[i] << (i * LANE_W));
      w.addr = m_base + 32'(BPP * (m_line * W + m_x - (LANES - 1)));
      pix.delete();
      if (!full_pre || popped) q.push_back(w);
      else m_ovf = 1'b1;
      if (m_x == W - 1 && m_line == H - 1) begin
        m_fdone = 1'b1;
        m_mode  = 2;
      end
    end
    m_x++;
  endtask

  task automatic model_update();
    bit popped, full_pre;
    if (!rst_n) begin
      model_clear();
      return;
    end
    popped   = (q.size() != 0) && wrready;
    full_pre = (q.size() == D);
    if (popped) q.delete(0);
    m_fdone = 1'b0;
    if (inde) begin
      if (indat[25]) begin
        m_mode = 1; m_x = 0; m_line = 0; m_base = fbbase; m_ovf = 1'b0;
        pix.delete();
        model_pixel(full_pre, popped);
      end else if (m_mode == 1) begin
        if (indat[24]) begin
          pix.delete();
          if (m_line == H - 1) m_mode = 2;
          else begin
            m_line++;
            m_x = 0;
            model_pixel(full_pre, popped);
          end
        end else begin
          model_pixel(full_pre, popped);
        end
      end
    end
  endtask

  task automatic step();
    if (wrvalid && wrready) dut_pops++;
    @(posedge clk);
    model_update();
    #1;
    if (fdone) dut_fdones++;
    check_output("wrvalid", 64'(wrvalid), 64'(q.size() != 0));
    check_output("overflow", 64'(overflow), 64'(m_ovf));
    check_output("fdone", 64'(fdone), 64'(m_fdone));
    if (q.size() != 0) begin
      check_output("wraddr", 64'(wraddr), 64'(q[0].addr));
      check_output("wrdata", wrdata, q[0].data);
    end
  endtask

  task automatic apply_stimulus(logic de, logic [25:0] dat, logic rdy);
    inde = de; indat = dat; wrready = rdy;
    step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_clear();
    check_output("rst_wrvalid", 64'(wrvalid), 64'd0);
    check_output("rst_overflow", 64'(overflow), 64'd0);
    check_output("rst_fdone", 64'(fdone), 64'd0);
    check_output("rst_wraddr", 64'(wraddr), 64'd0);
    check_output("rst_wrdata", wrdata, 64'd0);
    inde = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic send_frame(logic [31:0] base);
    fbbase = base;
    for (int l = 0; l < H; l++)
      for (int p = 0; p < W; p++)
        apply_stimulus(1'b1, {(l == 0 && p == 0), (l != 0 && p == 0), 24'($urandom())}, 1'b1);
  endtask

  task automatic idle(int n, logic rdy);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, '0, rdy);
  endtask

  vec_t        vecs[$];
  int          f0, p0, drv_x, extra;
  logic        de, s_of, s_ol;
  logic [63:0] head;

  initial begin
`ifdef INPACK_RGB565_EN
    vecs.push_back('{1'b1, 26'h2FF0000, 1'b1, 1'b0, 32'h0, 64'h0});
    vecs.push_back('{1'b1, 26'h000FF00, 1'b1, 1'b0, 32'h0, 64'h0});
    vecs.push_back('{1'b1, 26'h00000FF, 1'b1, 1'b0, 32'h0, 64'h0});
    vecs.push_back('{1'b1, 26'h0FFFFFF, 1'b1, 1'b1, 32'h1000, 64'hFFFF001F07E0F800});
    vecs.push_back('{1'b0, 26'h0, 1'b1, 1'b0, 32'h0, 64'h0});
`else
    vecs.push_back('{1'b1, 26'h2112233, 1'b1, 1'b0, 32'h0, 64'h0});
    vecs.push_back('{1'b1, 26'h0445566, 1'b1, 1'b1, 32'h1000, 64'h0044556600112233});
    vecs.push_back('{1'b0, 26'h0, 1'b0, 1'b1, 32'h1000, 64'h0044556600112233});
    vecs.push_back('{1'b1, 26'h0778899, 1'b0, 1'b1, 32'h1000, 64'h0044556600112233});
    vecs.push_back('{1'b1, 26'h0AABBCC, 1'b1, 1'b1, 32'h1008, 64'h00AABBCC00778899});
    vecs.push_back('{1'b1, 26'h0010203, 1'b1, 1'b0, 32'h0, 64'h0});
    vecs.push_back('{1'b1, 26'h1040506, 1'b1, 1'b0, 32'h0, 64'h0});
    vecs.push_back('{1'b1, 26'h0070809, 1'b1, 1'b1, 32'h1020, 64'h0007080900040506});
    vecs.push_back('{1'b0, 26'h0, 1'b1, 1'b0, 32'h0, 64'h0});
`endif
    #2;
    fbbase = 32'h1000;
    do_reset();
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].inde, vecs[i].dat, vecs[i].rdy);
      check_output($sformatf("vec%0d_wrvalid", i), 64'(wrvalid), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        check_output($sformatf("vec%0d_wraddr", i), 64'(wraddr), 64'(vecs[i].exp_addr));
        check_output($sformatf("vec%0d_wrdata", i), wrdata, vecs[i].exp_data);
      end
    end

    // Full frames, the second wrapping past the top of the address space.
    f0 = dut_fdones; p0 = dut_pops;
    send_frame(32'h0000_4000);
    idle(4, 1'b1);
    check_output("frame_fdone_count", 64'(dut_fdones - f0), 64'd1);
    check_output("frame_word_count", 64'(dut_pops - p0), 64'(W * H / LANES));
    p0 = dut_pops;
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, {2'b00, 24'($urandom())}, 1'b1);
    idle(2, 1'b1);
    check_output("done_ignores_pixels", 64'(dut_pops - p0), 64'd0);
    f0 = dut_fdones;
    send_frame(32'hFFFF_FFC0);
    idle(4, 1'b1);
    check_output("wrap_frame_fdone_count", 64'(dut_fdones - f0), 64'd1);

    // Writer stalled: FIFO fills, extra words drop, head holds; then drain and clear on SOF.
    fbbase = 32'h2000;
    for (int i = 0; i < (D + 4) * LANES; i++)
      apply_stimulus(1'b1, {(i == 0), (i != 0 && i % W == 0), 24'(i + 1)}, 1'b0);
    head = '0;
    for (int i = 0; i < LANES; i++) head = head | (lane_of(24'(i + 1)) << (i * LANE_W));
    check_output("ovf_set", 64'(overflow), 64'd1);
    check_output("ovf_head_addr", 64'(wraddr), 64'h2000);
    check_output("ovf_head_data", wrdata, head);
    p0 = dut_pops;
    idle(D + 4, 1'b1);
    check_output("ovf_held_words", 64'(dut_pops - p0), 64'(D));
    apply_stimulus(1'b1, {2'b10, 24'h123456}, 1'b1);
    check_output("ovf_cleared_by_sof", 64'(overflow), 64'd0);

    // Pixels before the first SOF and pixels past the line end produce nothing.
    do_reset();
    p0 = dut_pops;
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, {1'b0, (i == 3), 24'($urandom())}, 1'b1);
    idle(2, 1'b1);
    check_output("pre_sof_no_push", 64'(dut_pops - p0), 64'd0);
    apply_stimulus(1'b1, {2'b10, 24'($urandom())}, 1'b1);
    for (int i = 1; i < W + 5; i++) apply_stimulus(1'b1, {2'b00, 24'($urandom())}, 1'b1);
    idle(3, 1'b1);
    check_output("line_end_clip", 64'(dut_pops - p0), 64'(W / LANES));

    // Reset mid-line with queued words: everything is discarded until a new SOF.
    fbbase = 32'h3000;
    for (int i = 0; i < 2 * LANES + 1; i++)
      apply_stimulus(1'b1, {(i == 0), 1'b0, 24'($urandom())}, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check_output("midline_reset_wrvalid", 64'(wrvalid), 64'd0);
    idle(1, 1'b1);
    rst_n = 1'b1;
    p0 = dut_pops;
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, {2'b00, 24'($urandom())}, 1'b1);
    idle(2, 1'b1);
    check_output("post_reset_no_push", 64'(dut_pops - p0), 64'd0);

    // Randomized traffic against the model.
    drv_x = 0; extra = 0;
    fbbase = $urandom() & 32'hFFFF_FFF8;
    apply_stimulus(1'b1, {2'b10, 24'($urandom())}, 1'b1);
    drv_x = 1;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 9) == 0) fbbase = $urandom() & 32'hFFFF_FFF8;
      de = ($urandom_range(0, 3) != 0);
      s_of = 1'b0; s_ol = 1'b0;
      if (de) begin
        if ($urandom_range(0, 299) == 0) begin
          s_of = 1'b1; drv_x = 1;
        end else if (drv_x >= W + extra || $urandom_range(0, 59) == 0) begin
          s_ol = 1'b1; drv_x = 1; extra = $urandom_range(0, 2);
        end else begin
          drv_x++;
        end
      end
      apply_stimulus(de, {s_of, s_ol, 24'($urandom())}, ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
